// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared constants and the round-robin pick helper for the IRQ event scheduler
package irq_sched_pkg;

    localparam int unsigned MAX_SRC = 32;

    // Returns {found, id}: first set bit of pending at index >= ptr, wrapping at n.
    function automatic logic [5:0] rr_pick(
        input logic [MAX_SRC-1:0] pending,
        input logic [4:0]         ptr,
        input int unsigned        n
    );
        logic [5:0] res;
        logic [5:0] idx;
        res = '0;
        for (int unsigned k = 0; k < MAX_SRC; k++) begin
            idx = {1'b0, ptr} + 6'(k);
            if (idx >= 6'(n)) idx = idx - 6'(n);
            if (k < n && !res[5] && pending[idx[4:0]]) res = {1'b1, idx[4:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: synchronous FIFO with flush, usage count and optional fall-through
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [31:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned CW = ADDR_DEPTH + 1;

    dtype                  r_mem [DEPTH];
    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  w_bypass;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_unused;

    // Test mode only matters for clock gating, which this FIFO does not do.
    assign w_unused = testmode_i;
    assign full_o   = r_cnt == CW'(DEPTH);
    assign usage_o  = r_cnt[ADDR_DEPTH-1:0];
    assign w_bypass = FALL_THROUGH && (r_cnt == '0) && push_i && pop_i;
    assign w_wr     = push_i && !full_o && !w_bypass;
    assign w_rd     = pop_i && (r_cnt != '0);
    assign empty_o  = (r_cnt == '0) && !(FALL_THROUGH && push_i);
    assign data_o   = (FALL_THROUGH && r_cnt == '0) ? data_i : r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= (r_wr_ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= (r_rd_ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end

endmodule

// File: rtl/irq_event_scheduler.sv
// irq_event_scheduler: rising-edge IRQ capture with round-robin arbitration into an ID event FIFO
module irq_event_scheduler
    import irq_sched_pkg::*;
#(
    parameter int unsigned  NUM_SRC = 8,
    parameter int unsigned  DEPTH   = 4,
    localparam int unsigned IdW     = $clog2(NUM_SRC),
    localparam int unsigned LvlW    = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic [NUM_SRC-1:0] mask_i,
    input  logic [NUM_SRC-1:0] ovr_clr_i,
    output logic [IdW-1:0]     id_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] ovr_o,
    output logic [LvlW-1:0]    level_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] ovr_q;
    logic [IdW-1:0]     rr_q;
    logic [5:0]         w_pick;
    logic               w_gnt_valid;
    logic [IdW-1:0]     w_gnt_id;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_gnt_oh;
    logic [NUM_SRC-1:0] w_ovr_set;
    logic               w_full;
    logic               w_empty;
    logic [AW-1:0]      w_usage;

    // Edge detect, round-robin pick gated by FIFO full, and overrun detection
    always_comb begin
        w_edge      = irq_i & ~irq_prev_q & mask_i;
        w_pick      = rr_pick(MAX_SRC'(pending_q), 5'(rr_q), NUM_SRC);
        w_gnt_valid = w_pick[5] & ~w_full;
        w_gnt_id    = IdW'(w_pick[4:0]);
        w_gnt_oh    = NUM_SRC'(w_gnt_valid) << w_gnt_id;
        w_ovr_set   = flush_i ? '0 : w_edge & pending_q & ~w_gnt_oh;
    end

    // Pending/overrun bookkeeping; an edge landing on its own grant keeps the bit set
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            ovr_q      <= '0;
            rr_q       <= '0;
        end else begin
            irq_prev_q <= irq_i;
            pending_q  <= flush_i ? '0 : (pending_q & ~w_gnt_oh) | w_edge;
            ovr_q      <= (ovr_q & ~ovr_clr_i) | w_ovr_set;
            rr_q       <= flush_i ? '0 :
                          !w_gnt_valid ? rr_q :
                          (w_gnt_id == IdW'(NUM_SRC - 1)) ? '0 : w_gnt_id + 1'b1;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (DEPTH),
        .dtype        (logic [IdW-1:0])
    ) i_fifo (
        .clk_i      (clk_i),
        .rst_ni     (~rst_i),
        .flush_i    (flush_i),
        .testmode_i (1'b0),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .usage_o    (w_usage),
        .data_i     (w_gnt_id),
        .push_i     (w_gnt_valid),
        .data_o     (id_o),
        .pop_i      (valid_o & ready_i)
    );

    assign valid_o   = ~w_empty;
    assign pending_o = pending_q;
    assign ovr_o     = ovr_q;
    assign level_o   = w_full ? LvlW'(DEPTH) : LvlW'(w_usage);

endmodule

// File: tb/tb_irq_event_scheduler.sv
// tb_irq_event_scheduler: directed scenarios plus random traffic against a queue-based model
module tb_irq_event_scheduler;

    localparam int N = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, flush, ready;
    logic [7:0] irq, mask, ovr_clr;
    logic [2:0] id;
    logic       valid;
    logic [7:0] pending, ovr;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_pend, m_ovr, m_prev;
    int         m_rr;
    int         m_q[$];
    int         got[$];

    irq_event_scheduler #(.NUM_SRC(N), .DEPTH(D)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .irq_i     (irq),
        .mask_i    (mask),
        .ovr_clr_i (ovr_clr),
        .id_o      (id),
        .valid_o   (valid),
        .ready_i   (ready),
        .pending_o (pending),
        .ovr_o     (ovr),
        .level_o   (level)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0;
        m_ovr  = '0;
        m_prev = '0;
        m_rr   = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        logic [7:0] e, g;
        int gid, idx;
        if (rst) begin
            model_reset();
            return;
        end
        if (flush) begin
            m_pend = '0;
            m_q.delete();
            m_rr   = 0;
            m_ovr  = m_ovr & ~ovr_clr;
            m_prev = irq;
            return;
        end
        e   = irq & ~m_prev & mask;
        g   = '0;
        gid = -1;
        if (m_q.size() < D)
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (gid < 0 && m_pend[idx[2:0]]) gid = idx;
            end
        if (gid >= 0) g[gid[2:0]] = 1'b1;
        m_ovr  = (m_ovr & ~ovr_clr) | (e & m_pend & ~g);
        m_pend = (m_pend & ~g) | e;
        if (m_q.size() > 0 && ready) void'(m_q.pop_front());
        if (gid >= 0) begin
            m_q.push_back(gid);
            m_rr = (gid + 1) % N;
        end
        m_prev = irq;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; irq = '0; ovr_clr = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic collect(input int n);
        got.delete();
        for (int c = 0; c < 40 && got.size() < n; c++) begin
            if (valid && ready) got.push_back(int'(id));
            cyc();
        end
        checks++;
        if (got.size() != n) begin
            errors++;
            $display("FAIL collect_timeout got %0d ids want %0d", got.size(), n);
        end
    endtask

    task automatic test_reset();
        mask = 8'hFF; ready = 1'b0;
        do_reset();
        rst = 1'b1;
        cyc();
        checks++;
        if ({valid, level, id, pending, ovr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b l=%0d id=%0d p=%h o=%h want all 0", valid, level, id, pending, ovr);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b1; irq = 8'h20;
        cyc();
        checks++;
        if (pending !== 8'h20 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t1 got p=%h v=%b want p=20 v=0", pending, valid);
        end
        cyc();
        checks++;
        if (valid !== 1'b1 || id !== 3'd5 || level !== 3'd1) begin
            errors++;
            $display("FAIL single_t2 got v=%b id=%0d l=%0d want v=1 id=5 l=1", valid, id, level);
        end
        cyc();
        checks++;
        if (valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL single_t3 got v=%b l=%0d want v=0 l=0", valid, level);
        end
        irq = '0;
        cyc();
    endtask

    task automatic test_rr_order();
        do_reset();
        ready = 1'b1; irq = 8'h4A;
        collect(3);
        irq = '0;
        cyc();
        checks++;
        if (got.size() != 3 || got[0] != 1 || got[1] != 3 || got[2] != 6 || dut.rr_q !== 3'd7) begin
            errors++;
            $display("FAIL rr_from0 got %p rr=%0d want '{1,3,6} rr=7", got, dut.rr_q);
        end
        irq = 8'h08;
        collect(1);
        irq = '0;
        cyc();
        checks++;
        if (got.size() != 1 || got[0] != 3 || dut.rr_q !== 3'd4) begin
            errors++;
            $display("FAIL rr_prep got %p rr=%0d want '{3} rr=4", got, dut.rr_q);
        end
        irq = 8'h4A;
        collect(3);
        irq = '0;
        cyc();
        checks++;
        if (got.size() != 3 || got[0] != 6 || got[1] != 1 || got[2] != 3) begin
            errors++;
            $display("FAIL rr_from4 got %p want '{6,1,3}", got);
        end
    endtask

    task automatic test_fill();
        do_reset();
        ready = 1'b0; irq = 8'h3F;
        repeat (6) cyc();
        checks++;
        if (level !== 3'd4 || pending !== 8'h30 || valid !== 1'b1 || id !== 3'd0) begin
            errors++;
            $display("FAIL fill_full got l=%0d p=%h v=%b id=%0d want l=4 p=30 v=1 id=0", level, pending, valid, id);
        end
        ready = 1'b1;
        collect(6);
        checks++;
        if (got.size() != 6 || got[0] != 0 || got[1] != 1 || got[2] != 2 || got[3] != 3 || got[4] != 4 || got[5] != 5) begin
            errors++;
            $display("FAIL fill_drain got %p want '{0,1,2,3,4,5}", got);
        end
        irq = '0;
        cyc();
    endtask

    task automatic test_overrun();
        do_reset();
        ready = 1'b0; irq = 8'h1B;
        repeat (6) cyc();
        irq = 8'h1F;
        cyc();
        checks++;
        if (level !== 3'd4 || pending !== 8'h04 || ovr !== 8'h00) begin
            errors++;
            $display("FAIL ovr_setup got l=%0d p=%h o=%h want l=4 p=04 o=00", level, pending, ovr);
        end
        irq = 8'h1B;
        cyc();
        irq = 8'h1F;
        cyc();
        checks++;
        if (ovr !== 8'h04 || pending !== 8'h04) begin
            errors++;
            $display("FAIL ovr_set got o=%h p=%h want o=04 p=04", ovr, pending);
        end
        ovr_clr = 8'h04;
        cyc();
        ovr_clr = '0;
        checks++;
        if (ovr !== 8'h00) begin
            errors++;
            $display("FAIL ovr_clear got %h want 00", ovr);
        end
        irq = 8'h1B;
        cyc();
        irq = 8'h1F; ovr_clr = 8'h04;
        cyc();
        ovr_clr = '0;
        checks++;
        if (ovr !== 8'h04) begin
            errors++;
            $display("FAIL ovr_set_beats_clear got %h want 04", ovr);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++;
        if (level !== 3'd0 || valid !== 1'b0 || pending !== 8'h00 || ovr !== 8'h04) begin
            errors++;
            $display("FAIL flush_full got l=%0d v=%b p=%h o=%h want l=0 v=0 p=00 o=04", level, valid, pending, ovr);
        end
        irq = '0;
        cyc();
        irq = 8'h3F; ready = 1'b0;
        repeat (4) cyc();
        checks++;
        if (level !== 3'd3 || pending !== 8'h38) begin
            errors++;
            $display("FAIL flush_pre got l=%0d p=%h want l=3 p=38", level, pending);
        end
        flush = 1'b1; irq = 8'hBF; ready = 1'b1;
        cyc();
        flush = 1'b0;
        checks++;
        if (level !== 3'd0 || valid !== 1'b0 || pending !== 8'h00 || ovr !== 8'h04) begin
            errors++;
            $display("FAIL flush_lvl3 got l=%0d v=%b p=%h o=%h want l=0 v=0 p=00 o=04", level, valid, pending, ovr);
        end
        cyc();
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_edge_dropped got p=%h v=%b want p=00 v=0", pending, valid);
        end
    endtask

    task automatic test_mask();
        irq = '0;
        cyc();
        mask = 8'hEF; irq = 8'h10;
        repeat (3) cyc();
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL mask_ignore got p=%h v=%b l=%0d want p=00 v=0 l=0", pending, valid, level);
        end
        mask = 8'hFF; irq = '0;
        cyc();
    endtask

    task automatic test_async_reset();
        ready = 1'b0; irq = 8'h3F;
        repeat (3) cyc();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, level, id, pending, ovr} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%b l=%0d id=%0d p=%h o=%h want all 0", valid, level, id, pending, ovr);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc();
        checks++;
        if (pending !== 8'h3F || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_level_edge got p=%h v=%b want p=3F v=0", pending, valid);
        end
        irq = '0; ready = 1'b1;
        repeat (10) cyc();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            irq     = irq ^ (8'($urandom) & 8'($urandom));
            mask    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
            ready   = ($urandom_range(0, 15) < 6) ? 1'b0 : 1'b1;
            flush   = ($urandom_range(0, 60) == 0);
            ovr_clr = (!flush && $urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            cyc();
            checks++;
            if (valid !== (m_q.size() > 0) || level !== 3'(m_q.size())) begin
                errors++;
                $display("FAIL rnd_occ c=%0d got v=%b l=%0d want v=%b l=%0d", c, valid, level, m_q.size() > 0, m_q.size());
            end
            checks++;
            if (pending !== m_pend || ovr !== m_ovr) begin
                errors++;
                $display("FAIL rnd_bits c=%0d got p=%h o=%h want p=%h o=%h", c, pending, ovr, m_pend, m_ovr);
            end
            if (m_q.size() > 0) begin
                checks++;
                if (id !== 3'(m_q[0])) begin
                    errors++;
                    $display("FAIL rnd_id c=%0d got %0d want %0d", c, id, m_q[0]);
                end
            end
        end
        flush = 1'b0; ovr_clr = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ready = 1'b0;
        irq = '0; mask = 8'hFF; ovr_clr = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_rr_order();
        test_fill();
        test_overrun();
        test_flush();
        test_mask();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
